// File: rtl/sweep_controller.sv
// Triangle sweep sequencer: ramps count between latched low/high limits at a
// prescaled tick rate, dwells at each peak, and runs a finite or continuous
// number of sweeps. All outputs are registered.
module sweep_controller #(
  parameter int WIDTH   = 8,
  parameter int PRESC_W = 16,
  parameter int DWELL_W = 8,
  parameter int SWEEP_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               stop,
  input  logic [WIDTH-1:0]   lo_lim,
  input  logic [WIDTH-1:0]   hi_lim,
  input  logic [PRESC_W-1:0] step_div,
  input  logic [DWELL_W-1:0] dwell,
  input  logic [SWEEP_W-1:0] num_sweeps,
  output logic [WIDTH-1:0]   count,
  output logic               dir_up,
  output logic               busy,
  output logic               sweep_done,
  output logic               cfg_err,
  output logic [SWEEP_W-1:0] sweeps
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    RAMP_UP   = 3'd1,
    DWELL_HI  = 3'd2,
    RAMP_DOWN = 3'd3,
    DWELL_LO  = 3'd4
  } state_t;

  localparam logic [WIDTH-1:0]   CNT_ONE   = 1;
  localparam logic [PRESC_W-1:0] PRESC_ONE = 1;
  localparam logic [DWELL_W-1:0] DWELL_ONE = 1;
  localparam logic [SWEEP_W-1:0] SWEEP_ONE = 1;

  state_t             state_q;
  logic [WIDTH-1:0]   count_q;
  logic               dir_up_q;
  logic               busy_q;
  logic               sweep_done_q;
  logic               cfg_err_q;
  logic [SWEEP_W-1:0] sweeps_q;
  logic [PRESC_W-1:0] presc_q;
  logic [DWELL_W-1:0] dwell_cnt_q;

  // Configuration captured on an accepted start; data only, no reset needed.
  logic [WIDTH-1:0]   lo_q;
  logic [WIDTH-1:0]   hi_q;
  logic [PRESC_W-1:0] step_q;
  logic [DWELL_W-1:0] dwell_q;
  logic [SWEEP_W-1:0] nsw_q;

  logic               accept;
  logic               tick;
  logic [WIDTH-1:0]   cnt_up_d;
  logic [WIDTH-1:0]   cnt_dn_d;
  logic [SWEEP_W-1:0] sweeps_d;
  logic               last_sweep;

  // Combinational helpers: start qualification, tick and next-count values.
  always_comb begin
    accept     = (state_q == IDLE) && start && !stop && (lo_lim < hi_lim);
    tick       = (presc_q == step_q);
    cnt_up_d   = count_q + CNT_ONE;
    cnt_dn_d   = count_q - CNT_ONE;
    sweeps_d   = (sweeps_q == '1) ? sweeps_q : sweeps_q + SWEEP_ONE;
    last_sweep = (nsw_q != '0) && (sweeps_d == nsw_q);
  end

  // Latch the sweep configuration when a start is accepted.
  always_ff @(posedge clk) begin
    if (accept) begin
      lo_q    <= lo_lim;
      hi_q    <= hi_lim;
      step_q  <= step_div;
      dwell_q <= dwell;
      nsw_q   <= num_sweeps;
    end
  end

  // Sweep FSM with prescaler, dwell counter and registered status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      count_q      <= '0;
      dir_up_q     <= 1'b1;
      busy_q       <= 1'b0;
      sweep_done_q <= 1'b0;
      cfg_err_q    <= 1'b0;
      sweeps_q     <= '0;
      presc_q      <= '0;
      dwell_cnt_q  <= '0;
    end else begin
      sweep_done_q <= 1'b0;
      cfg_err_q    <= 1'b0;
      if (state_q == IDLE) begin
        presc_q <= '0;
        if (start && !stop) begin
          if (lo_lim < hi_lim) begin
            state_q  <= RAMP_UP;
            count_q  <= lo_lim;
            sweeps_q <= '0;
            dir_up_q <= 1'b1;
            busy_q   <= 1'b1;
          end else begin
            cfg_err_q <= 1'b1;
          end
        end
      end else if (stop) begin
        // Abort wins over any tick in the same cycle; count and sweeps hold.
        state_q <= IDLE;
        busy_q  <= 1'b0;
        presc_q <= '0;
      end else begin
        presc_q <= tick ? '0 : presc_q + PRESC_ONE;
        if (tick) begin
          case (state_q)
            RAMP_UP: begin
              count_q <= cnt_up_d;
              if (cnt_up_d == hi_q) begin
                if (dwell_q == '0) begin
                  state_q  <= RAMP_DOWN;
                  dir_up_q <= 1'b0;
                end else begin
                  state_q     <= DWELL_HI;
                  dwell_cnt_q <= dwell_q;
                end
              end
            end
            DWELL_HI: begin
              dwell_cnt_q <= dwell_cnt_q - DWELL_ONE;
              if (dwell_cnt_q == DWELL_ONE) begin
                state_q  <= RAMP_DOWN;
                dir_up_q <= 1'b0;
              end
            end
            RAMP_DOWN: begin
              count_q <= cnt_dn_d;
              if (cnt_dn_d == lo_q) begin
                sweep_done_q <= 1'b1;
                sweeps_q     <= sweeps_d;
                if (last_sweep) begin
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
                end else if (dwell_q == '0) begin
                  state_q  <= RAMP_UP;
                  dir_up_q <= 1'b1;
                end else begin
                  state_q     <= DWELL_LO;
                  dwell_cnt_q <= dwell_q;
                end
              end
            end
            DWELL_LO: begin
              dwell_cnt_q <= dwell_cnt_q - DWELL_ONE;
              if (dwell_cnt_q == DWELL_ONE) begin
                state_q  <= RAMP_UP;
                dir_up_q <= 1'b1;
              end
            end
            default: state_q <= IDLE;
          endcase
        end
      end
    end
  end

  assign count      = count_q;
  assign dir_up     = dir_up_q;
  assign busy       = busy_q;
  assign sweep_done = sweep_done_q;
  assign cfg_err    = cfg_err_q;
  assign sweeps     = sweeps_q;

endmodule

// File: tb/tb_sweep_controller.sv
// Self-checking bench for sweep_controller: table-driven basic sweep plus
// hand-written sequences, with expectations queued and popped after each edge.
module tb_sweep_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        stop;
  logic [7:0]  lo_lim;
  logic [7:0]  hi_lim;
  logic [15:0] step_div;
  logic [7:0]  dwell;
  logic [7:0]  num_sweeps;
  logic [7:0]  count;
  logic        dir_up;
  logic        busy;
  logic        sweep_done;
  logic        cfg_err;
  logic [7:0]  sweeps;

  sweep_controller #(
    .WIDTH(8), .PRESC_W(16), .DWELL_W(8), .SWEEP_W(8)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop),
    .lo_lim(lo_lim), .hi_lim(hi_lim), .step_div(step_div),
    .dwell(dwell), .num_sweeps(num_sweeps),
    .count(count), .dir_up(dir_up), .busy(busy),
    .sweep_done(sweep_done), .cfg_err(cfg_err), .sweeps(sweeps)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] cnt;
    logic       busy;
    logic       dir;
    logic       sd;
    logic       ce;
    logic [7:0] sw;
  } exp_t;

  typedef struct {
    logic       start;
    logic       stop;
    logic [7:0] cnt;
    logic       busy;
    logic       dir;
    logic       sd;
    logic       ce;
    logic [7:0] sw;
  } vec_t;

  exp_t exp_q[$];
  int   passed = 0;
  int   total  = 0;

  // Queue the expectation, advance one edge, then pop and compare.
  task automatic step_exp(input logic [7:0] c, input logic b, input logic d,
                          input logic sd, input logic ce, input logic [7:0] sw,
                          input string nm);
    exp_t e;
    e.cnt = c; e.busy = b; e.dir = d; e.sd = sd; e.ce = ce; e.sw = sw;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    total++;
    if (count === e.cnt && busy === e.busy && dir_up === e.dir &&
        sweep_done === e.sd && cfg_err === e.ce && sweeps === e.sw) begin
      passed++;
    end else begin
      $display("FAIL %s: got cnt=%0d busy=%0b dir=%0b done=%0b err=%0b sweeps=%0d, required cnt=%0d busy=%0b dir=%0b done=%0b err=%0b sweeps=%0d",
               nm, count, busy, dir_up, sweep_done, cfg_err, sweeps,
               e.cnt, e.busy, e.dir, e.sd, e.ce, e.sw);
    end
  endtask

  task automatic set_cfg(input logic [7:0] lo, input logic [7:0] hi,
                         input logic [15:0] div, input logic [7:0] dw,
                         input logic [7:0] ns);
    lo_lim = lo; hi_lim = hi; step_div = div; dwell = dw; num_sweeps = ns;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t basic[9];
    logic [7:0] c;
    logic [7:0] sw;
    int p;

    basic[0] = '{1'b1, 1'b0, 8'd2, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0};
    basic[1] = '{1'b0, 1'b0, 8'd3, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0};
    basic[2] = '{1'b0, 1'b0, 8'd4, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0};
    basic[3] = '{1'b0, 1'b0, 8'd5, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0};
    basic[4] = '{1'b0, 1'b0, 8'd5, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0};
    basic[5] = '{1'b0, 1'b0, 8'd4, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0};
    basic[6] = '{1'b0, 1'b0, 8'd3, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0};
    basic[7] = '{1'b0, 1'b0, 8'd2, 1'b0, 1'b0, 1'b1, 1'b0, 8'd1};
    basic[8] = '{1'b0, 1'b0, 8'd2, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1};

    rst = 1'b1; start = 1'b0; stop = 1'b0;
    set_cfg(8'd0, 8'd0, 16'd0, 8'd0, 8'd0);
    step_exp(8'd0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0, "reset0");
    step_exp(8'd0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0, "reset1");
    rst = 1'b0;

    // Basic sweep from the vector table.
    set_cfg(8'd2, 8'd5, 16'd0, 8'd1, 8'd1);
    for (int i = 0; i < 9; i++) begin
      start = basic[i].start;
      stop  = basic[i].stop;
      step_exp(basic[i].cnt, basic[i].busy, basic[i].dir, basic[i].sd,
               basic[i].ce, basic[i].sw, $sformatf("basic[%0d]", i));
    end
    start = 1'b0; stop = 1'b0;

    // Prescaler: each value lasts step_div+1 = 3 cycles.
    set_cfg(8'd2, 8'd5, 16'd2, 8'd1, 8'd1);
    for (int i = 0; i < 10; i++) begin
      start = (i == 0);
      c = 8'(2 + i / 3);
      step_exp(c, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0, $sformatf("presc[%0d]", i));
    end
    start = 1'b0; stop = 1'b1;
    step_exp(8'd5, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0, "presc_stop");
    stop = 1'b0;

    // Continuous triangle with no dwell; a start mid-run must be ignored.
    set_cfg(8'd0, 8'd3, 16'd0, 8'd0, 8'd0);
    for (int i = 0; i < 19; i++) begin
      start = (i == 0) || (i == 4);
      if (i == 4) begin
        lo_lim = 8'd1; hi_lim = 8'd9;
      end
      p  = i % 6;
      c  = (p <= 3) ? 8'(p) : 8'(6 - p);
      sw = 8'(i / 6);
      step_exp(c, 1'b1, (p < 3), (i > 0 && p == 0), 1'b0, sw,
               $sformatf("cont[%0d]", i));
    end
    start = 1'b0; stop = 1'b1;
    step_exp(8'd0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd3, "cont_stop");
    stop = 1'b0;

    // Abort at count 14 during the up ramp, then restart.
    set_cfg(8'd10, 8'd20, 16'd0, 8'd2, 8'd1);
    for (int i = 0; i < 5; i++) begin
      start = (i == 0);
      step_exp(8'(10 + i), 1'b1, 1'b1, 1'b0, 1'b0, 8'd0,
               $sformatf("abort_ramp[%0d]", i));
    end
    start = 1'b0; stop = 1'b1;
    step_exp(8'd14, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0, "abort_stop");
    stop = 1'b0;
    step_exp(8'd14, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0, "abort_hold");
    start = 1'b1;
    step_exp(8'd10, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0, "abort_restart");
    start = 1'b0; stop = 1'b1;
    step_exp(8'd10, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0, "restart_stop");
    stop = 1'b0;

    // Rejected configuration and start/stop priority in IDLE.
    set_cfg(8'd7, 8'd7, 16'd0, 8'd1, 8'd1);
    start = 1'b1;
    step_exp(8'd10, 1'b0, 1'b1, 1'b0, 1'b1, 8'd0, "cfg_err_pulse");
    start = 1'b0;
    step_exp(8'd10, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0, "cfg_err_clear");
    set_cfg(8'd1, 8'd4, 16'd0, 8'd1, 8'd1);
    start = 1'b1; stop = 1'b1;
    step_exp(8'd10, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0, "start_stop_idle");
    start = 1'b0; stop = 1'b0;
    step_exp(8'd10, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0, "start_stop_after");

    // Full-range sweep: 0 up to 255 and back, no wrap.
    set_cfg(8'd0, 8'd255, 16'd0, 8'd0, 8'd1);
    for (int i = 0; i < 512; i++) begin
      start = (i == 0);
      c  = (i <= 255) ? 8'(i) : ((i <= 510) ? 8'(510 - i) : 8'd0);
      sw = (i >= 510) ? 8'd1 : 8'd0;
      step_exp(c, (i < 510), (i < 255), (i == 510), 1'b0, sw,
               $sformatf("full[%0d]", i));
    end
    start = 1'b0;

    // Reset during DWELL_HI after one completed sweep, with start asserted.
    set_cfg(8'd2, 8'd3, 16'd0, 8'd1, 8'd0);
    start = 1'b1;
    step_exp(8'd2, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0, "rstmid_start");
    start = 1'b0;
    step_exp(8'd3, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0, "rstmid_hi");
    step_exp(8'd3, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, "rstmid_dwell_out");
    step_exp(8'd2, 1'b1, 1'b0, 1'b1, 1'b0, 8'd1, "rstmid_done");
    step_exp(8'd2, 1'b1, 1'b1, 1'b0, 1'b0, 8'd1, "rstmid_dwell_lo");
    step_exp(8'd3, 1'b1, 1'b1, 1'b0, 1'b0, 8'd1, "rstmid_dwell_hi");
    rst = 1'b1; start = 1'b1;
    step_exp(8'd0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0, "rstmid_reset");
    rst = 1'b0; start = 1'b0;
    step_exp(8'd0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0, "rstmid_after");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/sweep_controller.md
Name: sweep_controller

Overview:
Self-contained up/down count sequencer that generates a bounded triangle sweep between programmable low and high limits. A prescaled step tick, programmable dwell at each peak, and a finite or continuous sweep count control the sweep. It sits above the up/down counter datapath and adds the hold, limit and scheduling control that a raw enable-driven counter lacks. It produces the count value and status for display and downstream logic.

Parameters:
WIDTH, 8, width of count, lo_lim, hi_lim
PRESC_W, 16, width of step divider
DWELL_W, 8, width of dwell length
SWEEP_W, 8, width of sweep-count config and counter

Ports:
clk  in  1  clock
rst  in  1  reset: rst, synchronous, active-high; clock clk
start  in  1  single-cycle start request
stop  in  1  single-cycle abort request
lo_lim  in  WIDTH  lower sweep limit (unsigned)
hi_lim  in  WIDTH  upper sweep limit (unsigned)
step_div  in  PRESC_W  tick period minus 1, in clk cycles
dwell  in  DWELL_W  ticks held at each peak
num_sweeps  in  SWEEP_W  full sweeps to run; 0 = continuous
count  out  WIDTH  current count value
dir_up  out  1  1 = ramping up or dwelling high-bound side; 0 = down
busy  out  1  high in every state except IDLE
sweep_done  out  1  one-cycle pulse when a down ramp reaches lo
cfg_err  out  1  one-cycle pulse when start is rejected
sweeps  out  SWEEP_W  completed sweeps since last start (saturating)

Behaviour:
- Reset values: count=0, dir_up=1, busy=0, sweep_done=0, cfg_err=0, sweeps=0, prescaler=0, dwell counter=0, state=IDLE.
- All outputs are registered and update only on the rising edge of clk.
- States: IDLE, RAMP_UP, DWELL_HI, RAMP_DOWN, DWELL_LO.
- Configuration (lo_lim, hi_lim, step_div, dwell, num_sweeps) is latched on an accepted start. Input changes while busy are ignored.
- IDLE, start=1, stop=0, lo_lim<hi_lim: accept the start. Next state RAMP_UP, count<=lo_lim, prescaler<=0, sweeps<=0, dir_up<=1.
- IDLE, start=1, lo_lim>=hi_lim: reject the start. cfg_err pulses 1 cycle, state stays IDLE, count is unchanged.
- Tick generation:
  - The prescaler counts 0..step_div.
  - tick=1 in the cycle where prescaler==step_div; the prescaler then wraps to 0.
  - step_div=0 gives a tick every cycle.
  - The prescaler runs only while busy and is cleared on entering any state.
- RAMP_UP: on each tick, count<=count+1. On the tick that makes count==hi, move to DWELL_HI with the dwell counter loaded to dwell. If dwell==0, move directly to RAMP_DOWN.
- DWELL_HI / DWELL_LO:
  - count holds.
  - The dwell counter decrements on each tick.
  - On the tick where it reaches 0, move to the next ramp.
  - dir_up<=0 on leaving DWELL_HI; dir_up<=1 on leaving DWELL_LO.
- RAMP_DOWN: on each tick, count<=count-1. On the tick that makes count==lo:
  - sweep_done pulses in the same cycle count first shows lo.
  - sweeps increments, saturating at all-ones.
  - If num_sweeps!=0 and the new sweeps value equals num_sweeps: go to IDLE; busy drops on the same edge.
  - Otherwise go to DWELL_LO, or directly to RAMP_UP if dwell==0.
- Count never wraps, because it is bounded by [lo, hi]. hi_lim = 2^WIDTH-1 and lo_lim = 0 are legal.
- stop in any non-IDLE state: next state IDLE, count holds its current value, no sweep_done pulse, sweeps holds. stop takes priority over a tick in the same cycle.
- start while busy is ignored. start and stop in the same cycle in IDLE: stop wins and nothing happens.
- rst asserted mid-operation forces all reset values on the next edge, regardless of start or stop.

Test Plan:
- Basic sweep: reset, then lo=2, hi=5, step_div=0, dwell=1, num_sweeps=1, pulse start.
  - Required: count on successive cycles after start is 2,3,4,5,5,4,3,2.
  - sweep_done=1 exactly in the cycle count returns to 2; busy=0 from that cycle; sweeps=1.
- Prescaler: same config with step_div=2.
  - Required: each count value persists 3 cycles; total ramp-up from 2 to 5 takes 9 cycles.
- Continuous run and dwell=0: lo=0, hi=3, dwell=0, num_sweeps=0.
  - Required: count is 0,1,2,3,2,1,0,1,2,3 with no repeated peaks.
  - sweep_done pulses every 6 ticks; after 3 pulses sweeps=3; busy stays 1.
- Abort: start a sweep with lo=10, hi=20, then pulse stop when count=14 during RAMP_UP.
  - Required: next cycle busy=0, count stays 14, no sweep_done.
  - A following start is accepted and count restarts at 10.
- Config error and priority:
  - start with lo=7, hi=7: cfg_err pulses 1 cycle, busy stays 0.
  - start+stop together in IDLE: no state change.
  - start while busy: ignored, sequence unaffected.
- Reset mid-run: assert rst during DWELL_HI with count=hi.
  - Required: next cycle count=0, busy=0, dir_up=1, sweeps=0, no pulses.
